// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - processor data bus bundle for the counter controller
interface counter_ctrl_if;
  logic        bus_sel;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_sel,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_sel,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - memory-mapped pulse generator driving the counter peripheral
module counter_ctrl #(
  parameter int WIDTH  = 7,
  parameter int PWIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  counter_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] counter_N,
  output logic             counter_en,
  input  logic             counter_done,
  input  logic [31:0]      counter_out,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WAIT  = 2'd2,
    PULSE = 2'd3
  } state_t;

  // Runaway guard: 2^WIDTH + 1 pulses without counter_done is an error.
  localparam logic [WIDTH:0]  P_LIMIT = {1'b1, {(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]  P_ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [PWIDTH-1:0] T_ONE = {{(PWIDTH-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [WIDTH-1:0]  r_n;
  logic [PWIDTH-1:0] r_period;
  logic [PWIDTH-1:0] r_timer;
  logic [WIDTH:0]    r_pulses;
  logic              r_irq_en;
  logic              r_done;
  logic              r_err;

  logic w_busy;
  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_start;
  logic w_abort;
  logic w_unused;

  assign w_busy      = (r_state != IDLE);
  assign w_wr        = bus.bus_sel && bus.bus_we;
  assign w_wr_ctrl   = w_wr && (bus.bus_addr == 3'd0);
  assign w_wr_status = w_wr && (bus.bus_addr == 3'd3);
  assign w_start     = w_wr_ctrl && bus.bus_wdata[0];
  assign w_abort     = w_wr_ctrl && bus.bus_wdata[1];
  assign w_unused    = ^bus.bus_wdata[31:PWIDTH];

  // Outputs decoded from registered state only, so they cannot glitch.
  assign counter_en = (r_state == PULSE);
  assign counter_N  = w_busy ? r_n : '0;
  assign irq        = r_done && r_irq_en;

  // Configuration registers; N and PERIOD are frozen while an operation runs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_n      <= '0;
      r_period <= '0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_irq_en <= bus.bus_wdata[2];
      end
      if (w_wr && !w_busy && (bus.bus_addr == 3'd1)) begin
        r_n <= bus.bus_wdata[WIDTH-1:0];
      end
      if (w_wr && !w_busy && (bus.bus_addr == 3'd2)) begin
        r_period <= bus.bus_wdata[PWIDTH-1:0];
      end
    end
  end

  // Sequencer FSM plus sticky status; FSM sets are written after the W1C so they win.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_pulses <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_status) begin
        if (bus.bus_wdata[1]) r_done <= 1'b0;
        if (bus.bus_wdata[2]) r_err  <= 1'b0;
      end
      if (w_abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              if (r_n != '0) r_state <= ARM;
              else           r_err   <= 1'b1;
            end
          end
          ARM: begin
            r_timer  <= r_period;
            r_pulses <= '0;
            r_state  <= WAIT;
          end
          WAIT: begin
            if (counter_done) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else if (r_pulses == P_LIMIT) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else if (r_timer == '0) begin
              r_state <= PULSE;
            end else begin
              r_timer <= r_timer - T_ONE;
            end
          end
          PULSE: begin
            if (r_pulses != P_LIMIT) r_pulses <= r_pulses + P_ONE;
            // PULSE itself is one cycle of the interval, so reload one short
            // to keep rising edges PERIOD+1 apart (2 apart when PERIOD is 0).
            r_timer <= (r_period == '0) ? '0 : (r_period - T_ONE);
            r_state <= WAIT;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Single-cycle combinational readback.
  always_comb begin
    bus.bus_rdata = 32'd0;
    case (bus.bus_addr)
      3'd0:    bus.bus_rdata = {29'd0, r_irq_en, 2'b00};
      3'd1:    bus.bus_rdata = {{(32-WIDTH){1'b0}}, r_n};
      3'd2:    bus.bus_rdata = {{(32-PWIDTH){1'b0}}, r_period};
      3'd3:    bus.bus_rdata = {28'd0, r_err, r_done, w_busy};
      3'd4:    bus.bus_rdata = counter_out;
      default: bus.bus_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed self-checking bench for counter_ctrl
module tb_counter_ctrl;
  localparam int WIDTH = 7;
  localparam logic [31:0] OUT_MASK = 32'hCAFE0000;

  logic             clk = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] counter_N;
  logic             counter_en;
  logic             counter_done;
  logic [31:0]      counter_out;
  logic             irq;

  counter_ctrl_if bus ();

  counter_ctrl #(.WIDTH(WIDTH), .PWIDTH(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .counter_N    (counter_N),
    .counter_en   (counter_en),
    .counter_done (counter_done),
    .counter_out  (counter_out),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cyc;
  int pq[$];
  logic [31:0] cnt = 32'd0;
  logic        force_nodone = 1'b0;
  logic [31:0] rd;

  // Counter peripheral model: cleared while counter_N is 0, counts counter_en pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (counter_N == '0) cnt <= 32'd0;
    else if (counter_en) cnt <= cnt + 32'd1;
  end
  assign counter_done = !force_nodone && (counter_N != '0) && (cnt >= {25'd0, counter_N});
  assign counter_out  = cnt ^ OUT_MASK;

  always @(negedge clk) begin
    if (rstn && counter_en) pq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = a;
    #1;
    d = bus.bus_rdata;
    bus.bus_sel = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input int start, input int n, input int first, input int gap);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i < pq.size(); i++) if (pq[i] - pq[i-1] != gap) ok = 1'b0;
    check({tag, "_count"}, 32'(pq.size()), 32'(n));
    if (pq.size() > 0) check({tag, "_first"}, 32'(pq[0] - start), 32'(first));
    check({tag, "_gap"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int guard;
    rstn = 1'b0;
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 3'd0; bus.bus_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_counter_N", {25'd0, counter_N}, 32'd0);
    check("rst_counter_en", {31'd0, counter_en}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), rd);
      check($sformatf("rst_reg%0d", i), rd, (i == 4) ? OUT_MASK : 32'd0);
    end

    // N=14, PERIOD=1, irq enabled
    bus_write(3'd1, 32'd14);
    bus_write(3'd2, 32'd1);
    bus_write(3'd0, 32'd4);
    pq.delete();
    bus_write(3'd0, 32'd5);
    repeat (60) @(negedge clk);
    check_pulses("n14", wr_cyc, 14, 3, 2);
    bus_read(3'd3, rd); check("n14_status", rd, 32'd2);
    check("n14_irq", {31'd0, irq}, 32'd1);
    check("n14_counter_N", {25'd0, counter_N}, 32'd0);
    bus_read(3'd0, rd); check("n14_ctrl", rd, 32'd4);
    bus_write(3'd3, 32'd2);
    check("n14_irq_clr", {31'd0, irq}, 32'd0);

    // N=3, PERIOD=5, N write while busy ignored
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'd5);
    pq.delete();
    bus_write(3'd0, 32'd5);
    guard = wr_cyc;
    bus_write(3'd1, 32'd9);
    bus_read(3'd1, rd); check("n3_busy_write", rd, 32'd3);
    repeat (40) @(negedge clk);
    check_pulses("n3", guard, 3, 7, 6);
    bus_read(3'd3, rd); check("n3_status", rd, 32'd2);
    bus_write(3'd3, 32'd2);

    // N=10, PERIOD=3, abort after the 4th pulse then rerun
    bus_write(3'd1, 32'd10);
    bus_write(3'd2, 32'd3);
    pq.delete();
    bus_write(3'd0, 32'd5);
    guard = 0;
    while (pq.size() < 4 && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    bus_write(3'd0, 32'd6);
    check("abort_counter_N", {25'd0, counter_N}, 32'd0);
    repeat (30) @(negedge clk);
    check("abort_count", 32'(pq.size()), 32'd4);
    bus_read(3'd3, rd); check("abort_status", rd, 32'd0);
    pq.delete();
    bus_write(3'd0, 32'd5);
    repeat (60) @(negedge clk);
    check_pulses("rerun", wr_cyc, 10, 5, 4);
    bus_read(3'd3, rd); check("rerun_status", rd, 32'd2);
    bus_write(3'd3, 32'd2);

    // N=0 start -> err
    bus_write(3'd1, 32'd0);
    pq.delete();
    bus_write(3'd0, 32'd1);
    bus_read(3'd3, rd); check("n0_status", rd, 32'd4);
    repeat (10) @(negedge clk);
    check("n0_pulses", 32'(pq.size()), 32'd0);
    bus_write(3'd3, 32'd4);
    bus_read(3'd3, rd); check("n0_err_clr", rd, 32'd0);

    // Runaway guard with counter_done held low, PERIOD=0
    force_nodone = 1'b1;
    bus_write(3'd1, 32'd5);
    bus_write(3'd2, 32'd0);
    pq.delete();
    bus_write(3'd0, 32'd1);
    repeat (300) @(negedge clk);
    check_pulses("limit", wr_cyc, 129, 2, 2);
    bus_read(3'd3, rd); check("limit_status", rd, 32'd4);
    bus_write(3'd3, 32'd4);

    // Asynchronous reset while pulsing
    bus_write(3'd0, 32'd5);
    guard = 0;
    while (counter_en !== 1'b1 && guard < 50) begin
      @(negedge clk); guard++;
    end
    check("midrst_en_high", {31'd0, counter_en}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_en", {31'd0, counter_en}, 32'd0);
    check("midrst_counter_N", {25'd0, counter_N}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_read(3'(i), rd);
      check($sformatf("midrst_reg%0d", i), rd, 32'd0);
    end
    check("midrst_irq", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
